// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM command-bus arbiter: init, then fixed-priority refresh > write > read
// Grants are registered state decodes; the pin mux follows the current owner combinationally.
module sdram_arbit #(
  parameter int          ADDR_W  = 13,
  parameter int          BANK_W  = 2,
  parameter logic [3:0]  CMD_NOP = 4'b0111
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              flag_init_end,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              ref_req,
  input  logic              flag_ref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  output logic              ref_en,
  input  logic              wr_req,
  input  logic              flag_wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BANK_W-1:0] wr_bank,
  output logic              wr_en,
  input  logic              rd_req,
  input  logic              flag_rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BANK_W-1:0] rd_bank,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic [3:0]        sdram_cmd,
  output logic [BANK_W-1:0] sdram_bank,
  output logic [ADDR_W-1:0] sdram_addr
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ARBIT = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   ref_en_q, wr_en_q, rd_en_q, cke_q;

  // Every grant returns through ARBIT, which guarantees a NOP cycle between owners.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (flag_init_end) state_d = S_ARBIT;
      S_ARBIT: begin
        if (ref_req)     state_d = S_AREF;
        else if (wr_req) state_d = S_WRITE;
        else if (rd_req) state_d = S_READ;
      end
      S_AREF:  if (flag_ref_end) state_d = S_ARBIT;
      S_WRITE: if (flag_wr_end)  state_d = S_ARBIT;
      S_READ:  if (flag_rd_end)  state_d = S_ARBIT;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q  <= S_INIT;
      ref_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      cke_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_en_q <= (state_d == S_AREF);
      wr_en_q  <= (state_d == S_WRITE);
      rd_en_q  <= (state_d == S_READ);
      cke_q    <= 1'b1;
    end
  end

  assign ref_en    = ref_en_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign sdram_cke = cke_q;

  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = '0;
    sdram_bank = '0;
    case (state_q)
      S_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      S_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      S_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_bank = wr_bank;
      end
      S_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_arbit.sv
// tb/tb_sdram_arbit.sv - self-checking bench for sdram_arbit: vector table, corner sequences, random vs model
module tb_sdram_arbit;

  localparam int         ADDR_W  = 13;
  localparam int         BANK_W  = 2;
  localparam logic [3:0] CMD_NOP = 4'b0111;

  // Owner codes used by the table and the model
  localparam int O_INIT = 0, O_ARBIT = 1, O_AREF = 2, O_WR = 3, O_RD = 4;

  logic              sclk = 1'b0;
  logic              s_rst_n;
  logic              flag_init_end;
  logic [3:0]        init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [ADDR_W-1:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic [BANK_W-1:0] wr_bank, rd_bank;
  logic              ref_req, wr_req, rd_req;
  logic              flag_ref_end, flag_wr_end, flag_rd_end;
  logic              ref_en, wr_en, rd_en, sdram_cke;
  logic [3:0]        sdram_cmd;
  logic [BANK_W-1:0] sdram_bank;
  logic [ADDR_W-1:0] sdram_addr;

  int n_pass  = 0;
  int n_total = 0;

  sdram_arbit #(.ADDR_W(ADDR_W), .BANK_W(BANK_W), .CMD_NOP(CMD_NOP)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .flag_init_end(flag_init_end),
    .init_cmd(init_cmd), .init_addr(init_addr),
    .ref_req(ref_req), .flag_ref_end(flag_ref_end),
    .aref_cmd(aref_cmd), .aref_addr(aref_addr), .ref_en(ref_en),
    .wr_req(wr_req), .flag_wr_end(flag_wr_end),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_en(wr_en),
    .rd_req(rd_req), .flag_rd_end(flag_rd_end),
    .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd),
    .sdram_bank(sdram_bank), .sdram_addr(sdram_addr)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic init_end, ref_r, wr_r, rd_r, ref_e, wr_e, rd_e;
    int   owner;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  // Expected pins and grants for a given owner, from the current client buses
  task automatic check_out(input string tag, input int owner, input logic cke_exp);
    logic [2:0]        g;
    logic [3:0]        c;
    logic [ADDR_W-1:0] a;
    logic [BANK_W-1:0] b;
    g = 3'b000; c = CMD_NOP; a = '0; b = '0;
    case (owner)
      O_INIT: begin c = init_cmd; a = init_addr; end
      O_AREF: begin c = aref_cmd; a = aref_addr; g = 3'b001; end
      O_WR:   begin c = wr_cmd;   a = wr_addr;   b = wr_bank; g = 3'b010; end
      O_RD:   begin c = rd_cmd;   a = rd_addr;   b = rd_bank; g = 3'b100; end
      default: ;
    endcase
    check({tag, "_grants"}, 32'({rd_en, wr_en, ref_en}), 32'(g));
    check({tag, "_cmd"},    32'(sdram_cmd),  32'(c));
    check({tag, "_addr"},   32'(sdram_addr), 32'(a));
    check({tag, "_bank"},   32'(sdram_bank), 32'(b));
    check({tag, "_cke"},    32'(sdram_cke),  32'(cke_exp));
  endtask

  task automatic set_in(input vec_t v);
    flag_init_end = v.init_end;
    ref_req = v.ref_r; wr_req = v.wr_r; rd_req = v.rd_r;
    flag_ref_end = v.ref_e; flag_wr_end = v.wr_e; flag_rd_end = v.rd_e;
  endtask

  task automatic randomize_bus();
    init_cmd = 4'($urandom); aref_cmd = 4'($urandom);
    wr_cmd = 4'($urandom); rd_cmd = 4'($urandom);
    init_addr = 13'($urandom); aref_addr = 13'($urandom);
    wr_addr = 13'($urandom); rd_addr = 13'($urandom);
    wr_bank = 2'($urandom); rd_bank = 2'($urandom);
  endtask

  initial begin
    int   owner;
    logic init_seen;
    logic [2:0] req, fin;
    vec_t v;

    // init_end, ref, wr, rd, ref_end, wr_end, rd_end, expected owner after the edge
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_INIT};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_INIT};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_ARBIT};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_AREF};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, O_AREF};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_ARBIT};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_WR};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, O_WR};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_ARBIT};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_AREF};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_ARBIT};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_RD};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_ARBIT};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_WR};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_ARBIT};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_ARBIT};

    init_cmd = 4'h1; aref_cmd = 4'h2; wr_cmd = 4'h3; rd_cmd = 4'h4;
    init_addr = 13'h0111; aref_addr = 13'h0400; wr_addr = 13'h1abc; rd_addr = 13'h0def;
    wr_bank = 2'd2; rd_bank = 2'd1;
    set_in(vecs[0]);

    // Reset: cke low and INIT pins while held
    s_rst_n = 1'b0;
    repeat (2) @(negedge sclk);
    check_out("reset", O_INIT, 1'b0);
    s_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge sclk);
      check_out("init_wait", O_INIT, 1'b1);
    end

    for (int i = 0; i < 16; i++) begin
      set_in(vecs[i]);
      @(negedge sclk);
      check_out($sformatf("vec%0d", i), vecs[i].owner, 1'b1);
    end

    // WRITE: pins follow live wr_addr/wr_bank, foreign end flags ignored
    v = vecs[15]; v.wr_r = 1'b1; set_in(v);
    @(negedge sclk);
    v.wr_r = 1'b0; v.ref_e = 1'b1; v.rd_e = 1'b1; set_in(v);
    wr_addr = 13'h0555; wr_bank = 2'd3;
    #1 check_out("wr_track", O_WR, 1'b1);
    @(negedge sclk);
    check_out("wr_ignore_end", O_WR, 1'b1);
    v.ref_e = 1'b0; v.rd_e = 1'b0; v.wr_e = 1'b1; set_in(v);
    @(negedge sclk);
    check_out("wr_release", O_ARBIT, 1'b1);

    // Async reset mid-READ drops the grant and cke without a clock edge
    v = vecs[15]; v.rd_r = 1'b1; set_in(v);
    @(negedge sclk);
    check_out("rd_grant", O_RD, 1'b1);
    #2 s_rst_n = 1'b0;
    #1 check_out("async_rst", O_INIT, 1'b0);
    @(negedge sclk);
    s_rst_n = 1'b1;
    v = vecs[1]; set_in(v);
    for (int i = 0; i < 3; i++) begin
      @(negedge sclk);
      check_out("post_rst_init", O_INIT, 1'b1);
    end

    // Random phase against an owner-based model
    owner = O_INIT;
    init_seen = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check_out("rand", owner, 1'b1);
      if (!init_seen && $urandom_range(7) == 0) init_seen = 1'b1;
      flag_init_end = init_seen;
      req = 3'($urandom) & 3'($urandom);
      fin = 3'($urandom) & 3'($urandom);
      {rd_req, wr_req, ref_req} = req;
      {flag_rd_end, flag_wr_end, flag_ref_end} = fin;
      randomize_bus();
      @(posedge sclk);
      if (owner == O_INIT) begin
        if (flag_init_end) owner = O_ARBIT;
      end else if (owner == O_ARBIT) begin
        for (int k = 0; k < 3; k++)
          if (req[k]) begin owner = O_AREF + k; break; end
      end else if (fin[owner - O_AREF]) begin
        owner = O_ARBIT;
      end
      @(negedge sclk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
